// File: rtl/field_div2k.sv
// Field division by 2^k: c = a * 2^-k mod F_Q, one modular halving per RUN cycle.
// Optional macro FIELD_DIV2K_DOUBLE_STEP_EN chains two halvings per cycle.
module field_div2k #(
  parameter int                 K_BITS  = 6,
  parameter int                 F_NBITS = 61,
  parameter logic [F_NBITS-1:0] F_Q     = 61'h1FFF_FFFF_FFFF_FFFF
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [K_BITS-1:0]  k,
  output logic               ready_pulse,
  output logic               ready,
  output logic [F_NBITS-1:0] c
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_next;
  logic [F_NBITS-1:0] acc, acc_next;
  logic [K_BITS-1:0]  cnt, cnt_next;
  logic [F_NBITS-1:0] c_next;
  logic               ready_next;
  logic               pulse_next;

  // Odd values borrow F_Q first; the sum keeps its carry bit so the shift is exact.
  function automatic logic [F_NBITS-1:0] halve(input logic [F_NBITS-1:0] x);
    logic [F_NBITS:0] sum;
    sum = {1'b0, x} + (x[0] ? {1'b0, F_Q} : {(F_NBITS+1){1'b0}});
    return sum[F_NBITS:1];
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      acc         <= {F_NBITS{1'b0}};
      cnt         <= {K_BITS{1'b0}};
      c           <= {F_NBITS{1'b0}};
      ready       <= 1'b1;
      ready_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      cnt         <= cnt_next;
      c           <= c_next;
      ready       <= ready_next;
      ready_pulse <= pulse_next;
    end
  end

  // Next-state, datapath step and output decode.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    c_next     = c;
    ready_next = ready;
    pulse_next = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          acc_next   = a;
          cnt_next   = k;
          state_next = RUN;
          ready_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (cnt == {K_BITS{1'b0}}) begin
          c_next     = acc;
          ready_next = 1'b1;
          pulse_next = 1'b1;
          state_next = IDLE;
        end else begin
`ifdef FIELD_DIV2K_DOUBLE_STEP_EN
          if (cnt >= K_BITS'(2)) begin
            acc_next = halve(halve(acc));
            cnt_next = cnt - K_BITS'(2);
          end else begin
            acc_next = halve(acc);
            cnt_next = cnt - K_BITS'(1);
          end
`else
          acc_next = halve(acc);
          cnt_next = cnt - K_BITS'(1);
`endif
        end
      end
      default: begin
        state_next = IDLE;
        ready_next = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_field_div2k.sv
// Scoreboard bench for field_div2k: directed corner cases then random back-to-back runs.
module tb_field_div2k;

  localparam int               KB = 6;
  localparam int               NB = 61;
  localparam logic [NB-1:0]    Q  = 61'h1FFF_FFFF_FFFF_FFFF;

  logic          clk  = 1'b0;
  logic          rstb = 1'b0;
  logic          en   = 1'b0;
  logic [NB-1:0] a    = '0;
  logic [KB-1:0] k    = '0;
  logic          ready_pulse;
  logic          ready;
  logic [NB-1:0] c;

  int vectors     = 0;
  int miscompares = 0;
  logic [NB-1:0] sb[$];

  field_div2k #(.K_BITS(KB), .F_NBITS(NB), .F_Q(Q)) dut (
    .clk(clk), .rstb(rstb), .en(en), .a(a), .k(k),
    .ready_pulse(ready_pulse), .ready(ready), .c(c)
  );

  always #5 clk = ~clk;

  function automatic logic [NB-1:0] field_halve(input logic [NB-1:0] x);
    logic [NB:0] s;
    s = {1'b0, x};
    if (x[0]) s = s + {1'b0, Q};
    return s[NB:1];
  endfunction

  function automatic logic [NB-1:0] ref_div(input logic [NB-1:0] av, input logic [KB-1:0] kv);
    logic [NB-1:0] x;
    x = av;
    for (int i = 0; i < int'(kv); i++) x = field_halve(x);
    return x;
  endfunction

  function automatic logic [NB-1:0] dbl_mod(input logic [NB-1:0] x);
    logic [NB:0] y;
    y = {x, 1'b0};
    if (y >= {1'b0, Q}) y = y - {1'b0, Q};
    return y[NB-1:0];
  endfunction

  function automatic int exp_lat(input logic [KB-1:0] kv);
`ifdef FIELD_DIV2K_DOUBLE_STEP_EN
    return (int'(kv) + 1) / 2 + 1;
`else
    return int'(kv) + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start(input logic [NB-1:0] av, input logic [KB-1:0] kv);
    @(negedge clk);
    a  = av;
    k  = kv;
    en = 1'b1;
    sb.push_back(ref_div(av, kv));
    @(posedge clk);
    #1;
    en = 1'b0;
    a  = NB'({$urandom, $urandom});
    k  = KB'($urandom);
  endtask

  // Called #1 after the capture edge; waits for the completion pulse.
  task automatic finish_op(input string tag, input logic [KB-1:0] kv, output logic [NB-1:0] got);
    int lat = 0;
    int low = 0;
    bit done = 1'b0;
    logic [NB-1:0] expv;
    if (ready === 1'b0) low++;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready_pulse === 1'b1) done = 1'b1;
      else if (ready === 1'b0) low++;
    end
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat(kv)));
    check({tag, " ready_low_cycles"}, 64'(low), 64'(exp_lat(kv)));
    expv = (sb.size() > 0) ? sb.pop_front() : ~c;
    check({tag, " c"}, 64'(c), 64'(expv));
    check({tag, " ready"}, 64'(ready), 64'd1);
    got = c;
  endtask

  initial begin
    logic [NB-1:0] got;
    logic [NB-1:0] av;
    logic [NB-1:0] x;
    logic [KB-1:0] kv;
    int lat;
    int stray;
    bit done;

    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(ready), 64'd1);
    check("reset pulse", 64'(ready_pulse), 64'd0);
    check("reset c", 64'(c), 64'd0);
    @(negedge clk);
    rstb = 1'b1;

    start(61'd6, 6'd1);
    finish_op("a6k1", 6'd1, got);
    check("a6k1 value", 64'(got), 64'd3);
    @(posedge clk);
    #1;
    check("pulse drop", 64'(ready_pulse), 64'd0);
    check("c hold", 64'(c), 64'd3);

    start(61'd1, 6'd1);
    finish_op("a1k1", 6'd1, got);
    check("a1k1 half", 64'(got), 64'h1000_0000_0000_0000);

    start(61'd1, 6'd61);
    finish_op("a1k61", 6'd61, got);
    check("a1k61 value", 64'(got), 64'd1);

    start(61'd7, 6'd0);
    finish_op("a7k0", 6'd0, got);
    check("a7k0 value", 64'(got), 64'd7);

    start(61'd0, 6'd63);
    finish_op("a0k63", 6'd63, got);
    check("a0k63 value", 64'(got), 64'd0);

    // Second en during a busy run must be ignored.
    start(61'd8, 6'd3);
    @(posedge clk);
    #1;
    en = 1'b1; a = 61'd2; k = 6'd5;
    @(posedge clk);
    #1;
    en = 1'b0;
    lat = 2;
    done = 1'b0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready_pulse === 1'b1) done = 1'b1;
    end
    check("busy done", 64'(done), 64'd1);
    check("busy latency", 64'(lat), 64'(exp_lat(6'd3)));
    check("busy c", 64'(c), 64'(sb.pop_front()));
    stray = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (ready_pulse !== 1'b0 || ready !== 1'b1 || c !== 61'd1) stray++;
    end
    check("busy ignored", 64'(stray), 64'd0);

    // Reset mid-run, then en on the first edge after release.
    start(61'h123, 6'd20);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rstb = 1'b0;
    #1;
    check("midrst ready", 64'(ready), 64'd1);
    check("midrst c", 64'(c), 64'd0);
    check("midrst pulse", 64'(ready_pulse), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    check("midrst pulse held", 64'(ready_pulse), 64'd0);
    @(negedge clk);
    rstb = 1'b1;
    a = 61'd4; k = 6'd2; en = 1'b1;
    sb.push_back(ref_div(61'd4, 6'd2));
    @(posedge clk);
    #1;
    en = 1'b0;
    finish_op("post_rst", 6'd2, got);
    check("post_rst value", 64'(got), 64'd1);

    // Random runs, each started while the previous pulse is still high.
    for (int i = 0; i < 1000; i++) begin
      av = NB'({$urandom, $urandom});
      if (av >= Q) av = av - Q;
      kv = KB'($urandom_range(0, 63));
      start(av, kv);
      finish_op("rand", kv, got);
      x = got;
      for (int j = 0; j < int'(kv); j++) x = dbl_mod(x);
      check("rand inverse", 64'(x), 64'(av));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/field_div2k.md
FIELD_DIV2K -- requirements
Module: field_div2k

Interface
REQ-001 SHALL have parameter K_BITS, default 6, width of exponent input k (k up to 2^K_BITS-1).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rstb  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port en  input  1  start request, sampled on rising clk.
REQ-005 SHALL have port a  input  F_NBITS  field element to divide, required a < F_Q.
REQ-006 SHALL have port k  input  K_BITS  number of halvings (result = a * 2^-k mod F_Q).
REQ-007 SHALL have port ready_pulse  output  1  high exactly one cycle when a result completes.
REQ-008 SHALL have port ready  output  1  high when idle and c holds the last result.
REQ-009 SHALL have port c  output  F_NBITS  result, stable while ready is high.

Function
REQ-010 SHALL implement states IDLE and RUN only.
REQ-011 SHALL, in IDLE with en high at a clock edge, capture a into accumulator acc, k into counter cnt, enter RUN, drive ready low next cycle.
REQ-012 SHALL ignore en while in RUN; a and k need not be held after the capture edge.
REQ-013 SHALL, per RUN cycle with cnt != 0, set acc <= halve(acc) and cnt <= cnt-1.
REQ-014 SHALL define halve(x): x even -> x>>1; x odd -> (x + F_Q)>>1, sum computed at F_NBITS+1 bits with no truncation before the shift.
REQ-015 SHALL, in RUN with cnt == 0, register c <= acc, set ready and ready_pulse high next cycle, return to IDLE.
REQ-016 SHALL have latency k+1 cycles from capture edge to ready rising; k=0 gives 1 cycle with c = a.
REQ-017 SHALL deassert ready_pulse the cycle after it asserts, unless a new result completes.
REQ-018 SHALL accept en in the same cycle ready_pulse is high (back-to-back), capturing new operands on that edge.
REQ-019 SHALL keep every acc value in [0, F_Q) given a < F_Q; a = 0 yields c = 0 for any k.
REQ-020 SHALL hold c unchanged from a completion until the next completion.

Reset
REQ-021 SHALL, on rstb low, asynchronously force state IDLE, ready=1, ready_pulse=0, c=0, acc=0, cnt=0.
REQ-022 SHALL, if reset asserts mid-RUN, abandon the operation with no ready_pulse for it.
REQ-023 SHALL accept en on the first rising clk after rstb deasserts.

Configuration
REQ-024 SHALL support macro FIELD_DIV2K_DOUBLE_STEP_EN.
REQ-025 SHALL, with FIELD_DIV2K_DOUBLE_STEP_EN defined, apply two chained halvings per RUN cycle when cnt >= 2 (cnt -= 2), one when cnt == 1; latency ceil(k/2)+1 cycles.
REQ-026 SHALL, without FIELD_DIV2K_DOUBLE_STEP_EN, perform one halving per cycle as REQ-013/REQ-016; results SHALL be identical in both builds.

Verification
REQ-027 SHALL cover a=6, k=1 -> c=3, ready low 2 cycles, one ready_pulse.
REQ-028 SHALL cover a=1, k=1 -> c=(F_Q+1)/2 (F_HALF); with F_Q=2^61-1, a=1, k=61 -> c=1 after 62 cycles (31+1 with FIELD_DIV2K_DOUBLE_STEP_EN).
REQ-029 SHALL cover a=7, k=0 -> c=7 after 1 cycle; a=0, k=63 -> c=0.
REQ-030 SHALL cover en pulsed with a=2, k=5 while a run with a=8, k=3 is busy -> only c=1 produced, second en ignored.
REQ-031 SHALL cover rstb low mid-run (k=20, cycle 5) -> ready=1, c=0, no ready_pulse; next en with a=4, k=2 -> c=1.
REQ-032 SHALL cover 1000 random (a<F_Q, k) pairs -> c*2^k mod F_Q == a, checked against repeated field_halve reference model, both macro builds.
